// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, LSU state type and access-size helper.
`default_nettype none
/*----------------------------------------------------------------------------
 * Module   : dmem_pkg
 * Brief    : Types and helpers shared by the load/store unit and its RAM
 * Revision : 1.0
 *--------------------------------------------------------------------------*/
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Byte count of an access; the low two funct3 bits encode the size.
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = 4'd1;
            2'b01:   size_of = 4'd2;
            2'b10:   size_of = 4'd4;
            default: size_of = 4'd8;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bram.sv
// dmem_bram: single-port synchronous RAM, per-byte write enable, registered read.
`default_nettype none
/*----------------------------------------------------------------------------
 * Module   : dmem_bram
 * Brief    : Byte-enabled single-port RAM, no reset on contents or read data
 * Revision : 1.0
 *--------------------------------------------------------------------------*/
module dmem_bram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                                 clk,
    input  logic                                 en_i,
    input  logic                                 we_i,
    input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]   addr_i,
    input  logic [DATA_W/8-1:0]                  be_i,
    input  logic [DATA_W-1:0]                    wdata_i,
    output logic [DATA_W-1:0]                    rdata_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << (ADDR_W - OFF);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
// dmem_lsu: valid/ready load/store unit around dmem_bram with alignment
// and legality checking; one access per IDLE-ACCESS-RESP round.
`default_nettype none
/*----------------------------------------------------------------------------
 * Module   : dmem_lsu
 * Brief    : Load/store unit with sign/zero extension and error reporting
 * Revision : 1.0
 *--------------------------------------------------------------------------*/
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
            $error("dmem_lsu: DATA_W must be 32 or 64");
        end
    endgenerate

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic              accept;
    logic              f3_ok;
    logic              misaligned;
    logic              req_illegal;

    always_comb begin
        f3_ok = 1'b0;
        if (req_we) begin
            f3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                    (req_funct3 == F3_W) ||
                    ((req_funct3 == F3_D) && (DATA_W == 64));
        end else begin
            f3_ok = (req_funct3 == F3_B)  || (req_funct3 == F3_H)  ||
                    (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                    (req_funct3 == F3_HU) ||
                    (((req_funct3 == F3_D) || (req_funct3 == F3_WU)) && (DATA_W == 64));
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3)
            F3_H, F3_HU: misaligned = req_addr[0];
            F3_W, F3_WU: misaligned = |req_addr[1:0];
            F3_D:        misaligned = |req_addr[2:0];
            default:     misaligned = 1'b0;
        endcase
    end

    assign req_illegal = !f3_ok || misaligned;

    // Illegal requests skip ACCESS so the RAM is never touched for them.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = req_illegal ? RESP : ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_illegal;
            end
        end
    end

    logic              ram_en;
    logic [NB-1:0]     ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [OFF-1:0]    off;
    logic [3:0]        acc_size;
    logic [15:0]       size_mask;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_ext;

    assign off       = addr_q[OFF-1:0];
    assign acc_size  = size_of(f3_q);
    assign size_mask = (16'd1 << acc_size) - 16'd1;
    assign ram_be    = NB'(size_mask << off);
    // Asynchronous reset drops state_q out of ACCESS, which kills the enable.
    assign ram_en    = (state_q == ACCESS);

    always_comb begin
        ram_wdata = wdata_q;
        case (acc_size)
            4'd1:    ram_wdata = {NB{wdata_q[7:0]}};
            4'd2:    ram_wdata = {(NB/2){wdata_q[15:0]}};
            4'd4:    ram_wdata = {(NB/4){wdata_q[31:0]}};
            default: ram_wdata = wdata_q;
        endcase
    end

    dmem_bram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (we_q),
        .addr_i  (addr_q[ADDR_W-1:OFF]),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign lane = ram_rdata >> {off, 3'b000};

    always_comb begin
        load_ext = lane;
        case (f3_q)
            F3_B:    load_ext = DATA_W'($signed(lane[7:0]));
            F3_H:    load_ext = DATA_W'($signed(lane[15:0]));
            F3_W:    load_ext = DATA_W'($signed(lane[31:0]));
            F3_BU:   load_ext = DATA_W'(lane[7:0]);
            F3_HU:   load_ext = DATA_W'(lane[15:0]);
            F3_WU:   load_ext = DATA_W'(lane[31:0]);
            default: load_ext = lane;
        endcase
    end

    assign resp_rdata = (state_q == RESP && !we_q && !err_q) ? load_ext : '0;
    assign resp_err   = (state_q == RESP) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed vector table against 32- and 64-bit instances,
// plus stall and reset-during-access sequences.
`default_nettype none
/*----------------------------------------------------------------------------
 * Module   : tb_dmem_lsu
 * Brief    : Self-checking bench for dmem_lsu (DATA_W = 32 and 64)
 * Revision : 1.0
 *--------------------------------------------------------------------------*/
module tb_dmem_lsu;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic resp_ready = 1'b1;
    always #5 clk = ~clk;

    logic        v32, rdy32, we32, rv32, err32;
    logic [2:0]  f332;
    logic [8:0]  a32;
    logic [31:0] wd32, rd32;
    logic        v64, rdy64, we64, rv64, err64;
    logic [2:0]  f364;
    logic [8:0]  a64;
    logic [63:0] wd64, rd64;

    dmem_lsu #(.ADDR_W(9), .DATA_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid(v32), .req_ready(rdy32),
        .req_we(we32), .req_funct3(f332), .req_addr(a32), .req_wdata(wd32),
        .resp_valid(rv32), .resp_ready(resp_ready), .resp_rdata(rd32), .resp_err(err32)
    );

    dmem_lsu #(.ADDR_W(9), .DATA_W(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .req_valid(v64), .req_ready(rdy64),
        .req_we(we64), .req_funct3(f364), .req_addr(a64), .req_wdata(wd64),
        .resp_valid(rv64), .resp_ready(resp_ready), .resp_rdata(rd64), .resp_err(err64)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          w64;
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic        err;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input bit w64, input logic we, input logic [2:0] f3,
                         input logic [8:0] a, input logic [63:0] wd);
        if (w64) begin
            v64 = 1'b1; we64 = we; f364 = f3; a64 = a; wd64 = wd;
        end else begin
            v32 = 1'b1; we32 = we; f332 = f3; a32 = a; wd32 = wd[31:0];
        end
    endtask

    function automatic logic get_rv(input bit w64);
        return w64 ? rv64 : rv32;
    endfunction

    function automatic logic [63:0] get_rd(input bit w64);
        return w64 ? rd64 : {32'h0, rd32};
    endfunction

    function automatic logic get_err(input bit w64);
        return w64 ? err64 : err32;
    endfunction

    // Drive after an edge, count edges to resp_valid, let resp_ready complete it.
    task automatic txn(input bit w64, input logic we, input logic [2:0] f3,
                       input logic [8:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        issue(w64, we, f3, a, wd);
        @(posedge clk); #1;
        v32 = 1'b0; v64 = 1'b0;
        lat = 1;
        while (!get_rv(w64) && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = get_rd(w64);
        er = get_err(w64);
        @(posedge clk); #1;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;

    initial begin
        v32 = 0; we32 = 0; f332 = 0; a32 = 0; wd32 = 0;
        v64 = 0; we64 = 0; f364 = 0; a64 = 0; wd64 = 0;

        //           w64 we f3     addr    wdata                  rdata                  err lat name
        vecs.push_back('{0, 1, F3_W,  9'h10, 64'hDEADBEEF,         64'h0,                 0, 2, "sw_10"});
        vecs.push_back('{0, 0, F3_B,  9'h13, 64'h0,                64'hFFFFFFDE,          0, 2, "lb_13"});
        vecs.push_back('{0, 0, F3_BU, 9'h13, 64'h0,                64'h000000DE,          0, 2, "lbu_13"});
        vecs.push_back('{0, 0, F3_HU, 9'h12, 64'h0,                64'h0000DEAD,          0, 2, "lhu_12"});
        vecs.push_back('{0, 0, F3_H,  9'h10, 64'h0,                64'hFFFFBEEF,          0, 2, "lh_10"});
        vecs.push_back('{0, 1, F3_H,  9'h12, 64'hABCD1234,         64'h0,                 0, 2, "sh_12"});
        vecs.push_back('{0, 0, F3_W,  9'h10, 64'h0,                64'h1234BEEF,          0, 2, "lw_10_after_sh"});
        vecs.push_back('{0, 1, F3_W,  9'h20, 64'h11223344,         64'h0,                 0, 2, "sw_20"});
        vecs.push_back('{0, 1, F3_B,  9'h21, 64'hFFFFFF5A,         64'h0,                 0, 2, "sb_21"});
        vecs.push_back('{0, 0, F3_W,  9'h20, 64'h0,                64'h11225A44,          0, 2, "lw_20_after_sb"});
        vecs.push_back('{0, 0, F3_H,  9'h11, 64'h0,                64'h0,                 1, 1, "lh_11_misalign"});
        vecs.push_back('{0, 1, F3_W,  9'h22, 64'h99999999,         64'h0,                 1, 1, "sw_22_misalign"});
        vecs.push_back('{0, 0, F3_D,  9'h20, 64'h0,                64'h0,                 1, 1, "ld_on_32"});
        vecs.push_back('{0, 1, F3_D,  9'h20, 64'h0,                64'h0,                 1, 1, "sd_on_32"});
        vecs.push_back('{0, 0, F3_WU, 9'h20, 64'h0,                64'h0,                 1, 1, "lwu_on_32"});
        vecs.push_back('{0, 0, 3'b111,9'h20, 64'h0,                64'h0,                 1, 1, "load_f3_111"});
        vecs.push_back('{0, 0, F3_W,  9'h20, 64'h0,                64'h11225A44,          0, 2, "lw_20_unchanged"});
        vecs.push_back('{1, 1, F3_D,  9'h08, 64'h8000000000000001, 64'h0,                 0, 2, "sd_08"});
        vecs.push_back('{1, 0, F3_WU, 9'h0C, 64'h0,                64'h0000000080000000,  0, 2, "lwu_0c"});
        vecs.push_back('{1, 0, F3_W,  9'h0C, 64'h0,                64'hFFFFFFFF80000000,  0, 2, "lw_0c"});
        vecs.push_back('{1, 1, F3_D,  9'h0C, 64'h1234,             64'h0,                 1, 1, "sd_0c_misalign"});
        vecs.push_back('{1, 0, F3_D,  9'h08, 64'h0,                64'h8000000000000001,  0, 2, "ld_08"});
        vecs.push_back('{1, 0, F3_B,  9'h0F, 64'h0,                64'hFFFFFFFFFFFFFF80,  0, 2, "lb_0f"});
        vecs.push_back('{1, 0, F3_BU, 9'h08, 64'h0,                64'h0000000000000001,  0, 2, "lbu_08"});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready32", rdy32, 1);
        chk("rst_resp_valid32", rv32, 0);
        chk("rst_rdata32", rd32, 0);
        chk("rst_err32", err32, 0);
        chk("rst_req_ready64", rdy64, 1);
        chk("rst_resp_valid64", rv64, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].w64, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, er, lat);
            chk({vecs[i].nm, "_rdata"}, rd, vecs[i].rd);
            chk({vecs[i].nm, "_err"}, 64'(er), 64'(vecs[i].err));
            chk({vecs[i].nm, "_lat"}, 64'(lat), 64'(vecs[i].lat));
        end

        // Back-pressure: response held, a competing request must be ignored.
        resp_ready = 1'b0;
        @(posedge clk); #1;
        issue(0, 0, F3_W, 9'h20, 64'h0);
        @(posedge clk); #1;
        v32 = 1'b0;
        @(posedge clk); #1;
        chk("stall_resp_valid_start", rv32, 1);
        issue(0, 1, F3_W, 9'h20, 64'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_resp_valid", rv32, 1);
            chk("stall_rdata", {32'h0, rd32}, 64'h11225A44);
            chk("stall_req_ready", rdy32, 0);
        end
        v32 = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_resp_valid", rv32, 0);
        chk("release_req_ready", rdy32, 1);
        txn(0, 0, F3_W, 9'h20, 64'h0, rd, er, lat);
        chk("stall_store_ignored", rd, 64'h11225A44);

        // Reset lands while the store is in ACCESS: the write must be lost.
        txn(0, 1, F3_W, 9'h40, 64'h0, rd, er, lat);
        @(posedge clk); #1;
        issue(0, 1, F3_W, 9'h40, 64'hCAFEF00D);
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("access_req_ready", rdy32, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req_ready", rdy32, 1);
        chk("async_rst_resp_valid", rv32, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_resp_valid", rv32, 0);
        txn(0, 0, F3_W, 9'h40, 64'h0, rd, er, lat);
        chk("lw_40_after_rst", rd, 64'h0);
        chk("lw_40_after_rst_lat", 64'(lat), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
